// File: rtl/c3_pkg.sv
// Shared C3 definitions: BRAM geometry, weight-loader state encoding and write-port payload.
package c3_pkg;

  localparam int unsigned C3_DATA_W            = 8;
  localparam int unsigned C3_WPW               = 25;
  localparam int unsigned C3_RAM_WIDTH         = 200;
  localparam int unsigned C3_RAM_DEPTH         = 32;
  localparam int unsigned C3_NUM_BANKS         = 3;
  localparam int unsigned C3_WLOAD_TOTAL_WORDS = 96;

  localparam int unsigned C3_ADDR_W = $clog2(C3_RAM_DEPTH);
  localparam int unsigned C3_BANK_W = $clog2(C3_NUM_BANKS);
  localparam int unsigned C3_CNT_W  = $clog2(C3_WPW);
  localparam int unsigned C3_WIDX_W = $clog2(C3_WLOAD_TOTAL_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } c3_wload_state_e;

  typedef struct packed {
    logic [C3_NUM_BANKS-1:0] en;
    logic [C3_ADDR_W-1:0]    addr;
    logic [C3_RAM_WIDTH-1:0] data;
  } c3_wr_req_t;

  // One-hot bank write enable from a bank index.
  function automatic logic [C3_NUM_BANKS-1:0] c3_bank_onehot(input logic [C3_BANK_W-1:0] bank);
    return C3_NUM_BANKS'(1) << bank;
  endfunction

endpackage

// File: rtl/c3_weight_bram_loader_if.sv
// Weight byte stream (valid/ready) plus the shared C3 weight BRAM write port.
interface c3_weight_bram_loader_if;
  import c3_pkg::*;

  logic                    s_valid;
  logic [C3_DATA_W-1:0]    s_data;
  logic                    s_ready;
  logic [C3_ADDR_W-1:0]    wr_addr;
  logic [C3_RAM_WIDTH-1:0] wr_data;
  logic [C3_NUM_BANKS-1:0] wr_en;

  modport master (output s_valid, s_data, input s_ready, wr_addr, wr_data, wr_en);
  modport slave  (input s_valid, s_data, output s_ready, wr_addr, wr_data, wr_en);

endinterface

// File: rtl/c3_weight_packer.sv
// Packs accepted weight bytes LSB-first into one kernel word; flags the byte that completes it.
module c3_weight_packer
  import c3_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [C3_DATA_W-1:0]    data,
  output logic [C3_RAM_WIDTH-1:0] word_c,
  output logic                    word_full_c
);

  logic [C3_RAM_WIDTH-1:0] word_q;
  logic [C3_CNT_W-1:0]     cnt_q;

  // Word as it will look once the current byte is inserted at the counter slot.
  always_comb begin
    word_c = word_q;
    for (int k = 0; k < int'(C3_WPW); k++) begin
      if (cnt_q == C3_CNT_W'(k)) begin
        word_c[k*C3_DATA_W +: C3_DATA_W] = data;
      end
    end
    word_full_c = accept && (cnt_q == C3_CNT_W'(C3_WPW - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
    end else if (accept) begin
      word_q <= word_c;
      cnt_q  <= word_full_c ? '0 : cnt_q + C3_CNT_W'(1);
    end
  end

endmodule

// File: rtl/c3_weight_bram_loader.sv
// Streams C3 kernel weights into the three weight BRAM banks, one 25-byte word per write.
// Optional C3_WLOAD_CHECKSUM_EN adds a 16-bit sum of all accepted bytes.
module c3_weight_bram_loader
  import c3_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  c3_weight_bram_loader_if.slave   bus,
  output logic                     busy,
  output logic                     done
`ifdef C3_WLOAD_CHECKSUM_EN
  ,
  output logic [15:0]              checksum
`endif
);

  c3_wload_state_e         state_q, state_d;
  logic [C3_BANK_W-1:0]    bank_q, bank_d;
  logic [C3_ADDR_W-1:0]    addr_q, addr_d;
  c3_wr_req_t              wr_q, wr_d;
  logic                    s_ready_q, s_ready_d;
  logic                    busy_d, done_d;
  logic                    pack_clear;
  logic                    accept_c;
  logic                    last_word_c;
  logic [C3_RAM_WIDTH-1:0] word_c;
  logic                    word_full_c;

  assign accept_c    = bus.s_valid && s_ready_q;
  assign last_word_c = (C3_WIDX_W'(addr_q) * C3_WIDX_W'(C3_NUM_BANKS) + C3_WIDX_W'(bank_q))
                       == C3_WIDX_W'(C3_WLOAD_TOTAL_WORDS - 1);

  c3_weight_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (pack_clear),
    .accept      (accept_c),
    .data        (bus.s_data),
    .word_c      (word_c),
    .word_full_c (word_full_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wr_d.en    = '0;
    pack_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        pack_clear = 1'b1;
        if (start) begin
          state_d = LOAD;
          bank_d  = '0;
          addr_d  = '0;
        end
      end
      LOAD: begin
        if (word_full_c) begin
          state_d   = WRITE;
          wr_d.en   = c3_bank_onehot(bank_q);
          wr_d.addr = addr_q;
          wr_d.data = word_c;
        end
      end
      WRITE: begin
        // Banks rotate fastest; the address advances when the bank index wraps.
        if (bank_q == C3_BANK_W'(C3_NUM_BANKS - 1)) begin
          bank_d = '0;
          addr_d = addr_q + C3_ADDR_W'(1);
        end else begin
          bank_d = bank_q + C3_BANK_W'(1);
        end
        state_d = last_word_c ? DONE : LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d == LOAD);
    busy_d    = (state_d == LOAD) || (state_d == WRITE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= '0;
      addr_q    <= '0;
      wr_q      <= '0;
      s_ready_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      s_ready_q <= s_ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.wr_en   = wr_q.en;
  assign bus.wr_addr = wr_q.addr;
  assign bus.wr_data = wr_q.data;

`ifdef C3_WLOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if ((state_q == IDLE) && start) begin
      checksum <= '0;
    end else if (accept_c) begin
      checksum <= checksum + 16'(bus.s_data);
    end
  end
`endif

endmodule

// File: tb/tb_c3_weight_bram_loader.sv
// Directed bench for the C3 weight BRAM loader against a word-level reference model.
module tb_c3_weight_bram_loader;
  import c3_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
`ifdef C3_WLOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  c3_weight_bram_loader_if bus ();

  c3_weight_bram_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done)
`ifdef C3_WLOAD_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int total;
  int bad;

  // Reference model: byte log, words written so far, pending write / done flags.
  bit          m_run, m_wpend, m_done, m_sum_ok;
  int          m_nb, m_nw, run_wr;
  logic [7:0]  m_mem [2400];
  logic [15:0] m_sum;
  bit          pin1, ck_pin;
  logic [15:0] ck_lit;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int p, input int i);
    logic [31:0] iv;
    iv = 32'(i);
    case (p)
      0:       return iv[7:0];
      1:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic compare_step();
    logic [2:0]   exp_en;
    logic [199:0] ew;
    if (!rst_n) begin
      chk("rst_wr_en", 200'(bus.wr_en), 200'(0));
      chk("rst_busy", 200'(busy), 200'(0));
      chk("rst_done", 200'(done), 200'(0));
      chk("rst_s_ready", 200'(bus.s_ready), 200'(0));
      chk("rst_wr_addr", 200'(bus.wr_addr), 200'(0));
      m_run = 0; m_wpend = 0; m_done = 0; m_sum_ok = 0; run_wr = 0;
      return;
    end
    exp_en = m_wpend ? (3'b001 << (m_nw % 3)) : 3'b000;
    chk("wr_en", 200'(bus.wr_en), 200'(exp_en));
    if (bus.wr_en != 3'b000) run_wr++;
    if (m_wpend) begin
      ew = '0;
      for (int k = 0; k < 25; k++) ew[8*k +: 8] = m_mem[m_nw*25 + k];
      chk("wr_addr", 200'(bus.wr_addr), 200'(m_nw / 3));
      chk("wr_data", bus.wr_data, ew);
      if (pin1 && m_nw == 0) begin
        chk("pin_w0_en", 200'(bus.wr_en), 200'(3'b001));
        chk("pin_w0_addr", 200'(bus.wr_addr), 200'(0));
        chk("pin_w0_lo", 200'(bus.wr_data[7:0]), 200'(8'h00));
        chk("pin_w0_hi", 200'(bus.wr_data[199:192]), 200'(8'h18));
      end
      if (pin1 && m_nw == 1) begin
        chk("pin_w1_en", 200'(bus.wr_en), 200'(3'b010));
        chk("pin_w1_addr", 200'(bus.wr_addr), 200'(0));
        chk("pin_w1_lo", 200'(bus.wr_data[7:0]), 200'(8'h19));
      end
      if (pin1 && m_nw == 95) begin
        chk("pin_wlast_en", 200'(bus.wr_en), 200'(3'b100));
        chk("pin_wlast_addr", 200'(bus.wr_addr), 200'(31));
      end
    end
    chk("s_ready", 200'(bus.s_ready), 200'(m_run && !m_wpend));
    chk("busy", 200'(busy), 200'(m_run));
    chk("done", 200'(done), 200'(m_done));
    if (m_done) chk("writes_per_run", 200'(run_wr), 200'(96));
`ifdef C3_WLOAD_CHECKSUM_EN
    if (m_sum_ok) chk("checksum", 200'(checksum), 200'(m_sum));
    if (m_done && ck_pin) chk("checksum_lit", 200'(checksum), 200'(ck_lit));
`endif
    // Advance the model to what the next clock edge must produce.
    if (m_done) begin
      m_done = 0;
    end else if (m_wpend) begin
      m_wpend = 0;
      m_nw++;
      if (m_nw == 96) begin
        m_run = 0; m_done = 1; m_sum_ok = 1;
      end
    end else if (m_run) begin
      if (bus.s_valid && m_nb < 2400) begin
        m_mem[m_nb] = bus.s_data;
        m_sum = m_sum + 16'(bus.s_data);
        m_nb++;
        if (m_nb % 25 == 0) m_wpend = 1;
      end
    end else if (start) begin
      m_run = 1; m_nb = 0; m_nw = 0; m_sum = '0; m_sum_ok = 0; run_wr = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle, input int p, input int start_at);
    int i = 0;
    int cyc = 0;
    bit hold = 0;
    bit acc;
    while (i < n && cyc < n * 3 + 100) begin
      bus.s_valid = hold || !toggle || (cyc % 2 == 0);
      bus.s_data  = pat(p, i);
      start       = (i == start_at) && !hold;
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      cycle();
      start = 1'b0;
      if (acc) begin
        i++;
        hold = 0;
      end else begin
        hold = bus.s_valid;
      end
      cyc++;
    end
    bus.s_valid = 1'b0;
    chk("bytes_delivered", 200'(i), 200'(n));
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = done;
      cycle();
    end
    chk("done_seen", 200'(seen), 200'(1));
    repeat (2) cycle();
  endtask

  initial begin
    total = 0; bad = 0;
    m_run = 0; m_wpend = 0; m_done = 0; m_sum_ok = 0;
    m_nb = 0; m_nw = 0; run_wr = 0; m_sum = '0;
    pin1 = 0; ck_pin = 0; ck_lit = '0;
    rst_n = 1'b0; start = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    fork
      forever begin
        @(negedge clk);
        compare_step();
      end
    join_none
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Full-rate reload with literal pins on first, second and last writes.
    pin1 = 1;
    pulse_start();
    stream(2400, 0, 0, -1);
    wait_done();
    pin1 = 0;

    // Input valid toggling every cycle.
    pulse_start();
    stream(2400, 1, 0, -1);
    wait_done();

    // Second start mid-load is ignored.
    pulse_start();
    stream(2400, 0, 0, 100);
    wait_done();

    // Reset in the middle of the third word, then a fresh full run.
    pulse_start();
    stream(60, 0, 0, -1);
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    pulse_start();
    stream(2400, 0, 0, -1);
    wait_done();

    // Started but starved, then completed; start coinciding with done is ignored.
    pulse_start();
    repeat (50) cycle();
    stream(2400, 0, 0, -1);
    cycle();
    start = 1'b1;
    @(negedge clk);
    chk("done_cycle", 200'(done), 200'(1));
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    chk("idle_after_done_start", 200'(busy), 200'(0));

`ifdef C3_WLOAD_CHECKSUM_EN
    ck_pin = 1;
    ck_lit = 16'h56A0;
    pulse_start();
    stream(2400, 0, 1, -1);
    wait_done();
    ck_lit = 16'h0000;
    pulse_start();
    stream(2400, 0, 2, -1);
    wait_done();
    ck_pin = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
